led_pwm_pattern: RTL and testbench
==================================

Name: led_pwm_pattern

Overview:
Parametrised multi-channel LED driver, the next generation of the free-running-counter blinky. Each channel independently runs off, steady PWM dim, blink-at-duty, or triangle "breathe", all from one shared timebase. Mode and duty are double-buffered: a new setting takes effect only on a PWM period boundary, so there are no glitches. It sits between board-level control logic and the RGB LED / PMOD LED pins.

Parameters:
CHANNELS, 3, number of independent LED channels
PWM_BITS, 8, PWM resolution; PWM period = PRESCALE * 2^PWM_BITS clocks
PRESCALE, 187, clocks per PWM tick (min 1); 187 gives about 1 kHz PWM at 48 MHz
BLINK_BIT, 23, bit of the free-running blink counter (width BLINK_BIT+1) used as blink phase
BREATHE_DIV, 4, PWM periods per breathe-level step (min 1)
ACTIVE_LOW, 1, 1 = LED pin driven low when lit (on-board RGB); 0 = active high (PMOD)

Ports:
CLK_48  in  1  system clock, 48 MHz
RST  in  1  asynchronous reset, active high
MODE  in  2*CHANNELS  per-channel mode, ch k at [2k+1:2k]; 00 off, 01 steady, 10 blink, 11 breathe
DUTY  in  PWM_BITS*CHANNELS  per-channel duty, ch k at [PWM_BITS*k +: PWM_BITS]
LOAD  in  1  single-cycle strobe; captures MODE/DUTY into pending registers
PENDING  out  1  high from the cycle after LOAD until pending values are applied
PERIOD_STROBE  out  1  one-cycle pulse on each PWM period start
LED  out  CHANNELS  LED pin drive, polarity per ACTIVE_LOW

Behaviour:
- Reset (async, immediate): all counters 0; pending and active regs 0 (all channels off, duty 0); breathe level 0, direction up, breathe divider 0; PENDING=0; PERIOD_STROBE=0; every LED bit = ACTIVE_LOW (unlit). Asserting RST mid-pattern drops the LEDs to unlit in the same instant, with no clock required.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick = (presc == PRESCALE-1).
- PWM counter: PWM_BITS wide, increments on tick, wraps from 2^PWM_BITS-1 to 0. boundary = tick AND pwm_cnt == all-ones.
- PERIOD_STROBE: registered copy of boundary, so it is high in the first cycle with pwm_cnt = 0.
- Load handshake:
  - LOAD=1 captures MODE/DUTY into pending and sets PENDING.
  - On boundary with PENDING=1: active <= pending, PENDING <= 0.
  - LOAD on the same cycle as a boundary goes to pending only and is applied at the next boundary. The previously pending value is applied at this boundary.
  - A second LOAD before the boundary overwrites pending; last write wins.
- Blink counter: free-running, BLINK_BIT+1 bits, wraps naturally. blink_ph = its MSB.
- Breathe envelope (shared by all channels):
  - Divider counts boundaries 0..BREATHE_DIV-1. On wrap, the level steps by 1 in the current direction.
  - Direction flips to down when the level reaches 2^PWM_BITS-1, and to up when it reaches 0. The endpoints are each held for one step, with no skipped or overshot values.
- Effective duty per channel: eff = (DUTY_active * level) >> PWM_BITS, taking the upper PWM_BITS of the full 2*PWM_BITS product.
- Per-channel lit signal:
  - off: 0
  - steady: pwm_cnt < duty
  - blink: blink_ph AND (pwm_cnt < duty)
  - breathe: pwm_cnt < eff
  - Duty 0 is never lit. Duty all-ones is lit 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- LED[k] = lit_k XOR ACTIVE_LOW, registered: one clock of latency from counter state to pin.

Optional Feature:
Macro LED_PWM_GAMMA_EN.
- Defined: the compare value (duty, or eff in breathe) is replaced by (v*v) >> PWM_BITS before the compare. This gives a perceptual brightness curve; the extra multiply is on the compare path only.
- Undefined: linear compare as above.
- Timing, handshake and reset are identical in both builds.

Test Plan:
All scenarios use PWM_BITS=4, PRESCALE=2, BLINK_BIT=6, BREATHE_DIV=1, ACTIVE_LOW=1, CHANNELS=3, so the PWM period is 32 clocks.
- Reset: RST=1 with arbitrary inputs -> LED=3'b111, PENDING=0, PERIOD_STROBE=0 immediately. After release, PERIOD_STROBE first pulses 32 clocks later.
- Steady: LOAD ch0 mode 01 duty 4 -> PENDING=1 until the next boundary. Afterwards LED[0] is low for 8 of every 32 clocks, starting the cycle after PERIOD_STROBE; ch1 and ch2 stay high.
- Duty limits: ch0 duty 0 -> LED[0] never low. Duty 15 -> low 30 of every 32 clocks.
- Blink: ch1 mode 10 duty 15 -> PWM bursts only while blink MSB=1; the 128-clock blink period has 64 clocks with no low pulses.
- Breathe: ch2 mode 11 duty 15 -> level sequence 0..15..0 over 30 periods. eff=(15*level)>>4 in the linear build, and the squared curve when LED_PWM_GAMMA_EN is defined.
- Handshake corners: LOAD on a boundary cycle -> applied one period later. Two LOADs within one period -> only the second takes effect. RST mid-period -> LED=111 immediately and active modes cleared.

Source files
------------

// File: rtl/led_pwm_pattern_if.sv
// Control/status bundle for led_pwm_pattern: mode/duty load port plus LED and
// period status outputs.
interface led_pwm_pattern_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_BITS = 8
);
  logic [2*CHANNELS-1:0]        MODE;
  logic [PWM_BITS*CHANNELS-1:0] DUTY;
  logic                         LOAD;
  logic                         PENDING;
  logic                         PERIOD_STROBE;
  logic [CHANNELS-1:0]          LED;

  modport master (
    output MODE, DUTY, LOAD,
    input  PENDING, PERIOD_STROBE, LED
  );

  modport slave (
    input  MODE, DUTY, LOAD,
    output PENDING, PERIOD_STROBE, LED
  );
endinterface

// File: rtl/led_pwm_pattern.sv
// Multi-channel LED driver: off / steady PWM / blink / breathe per channel off a
// shared timebase, with period-aligned double-buffered settings.
// Optional macro LED_PWM_GAMMA_EN squares the compare value for a perceptual curve.
module led_pwm_pattern #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALE    = 187,
  parameter int unsigned BLINK_BIT   = 23,
  parameter int unsigned BREATHE_DIV = 4,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              CLK_48,
  input  logic              RST,
  led_pwm_pattern_if.slave  bus
);

  localparam int unsigned PW    = PWM_BITS;
  localparam int unsigned MW    = 2 * CHANNELS;
  localparam int unsigned DW    = PWM_BITS * CHANNELS;
  localparam int unsigned BW    = BLINK_BIT + 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DIV_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STEADY  = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;

  localparam logic [PW-1:0] LVL_TOP = {PW{1'b1}};

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PW-1:0]       pwm_q, pwm_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                strobe_q, strobe_d;
  logic [MW-1:0]       pend_mode_q, pend_mode_d;
  logic [DW-1:0]       pend_duty_q, pend_duty_d;
  logic                pending_q, pending_d;
  logic [MW-1:0]       act_mode_q, act_mode_d;
  logic [DW-1:0]       act_duty_q, act_duty_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PW-1:0]       level_q, level_d;
  logic [0:0]          dir_q, dir_d;
  logic [CHANNELS-1:0] led_q, led_d;

  logic                tick_c;
  logic                boundary_c;
  logic                step_c;

  logic [1:0]          ch_mode;
  logic [PW-1:0]       ch_duty;
  logic [PW-1:0]       ch_eff;
  logic [PW-1:0]       ch_sel;
  logic [PW-1:0]       ch_cmp;
  logic                ch_lit;

  // Timebase, load handshake and breathe envelope next-state
  always_comb begin
    tick_c      = 1'b0;
    boundary_c  = 1'b0;
    step_c      = 1'b0;
    presc_d     = presc_q;
    pwm_d       = pwm_q;
    blink_d     = blink_q;
    strobe_d    = 1'b0;
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    pending_d   = pending_q;
    act_mode_d  = act_mode_q;
    act_duty_d  = act_duty_q;
    div_d       = div_q;
    level_d     = level_q;
    dir_d       = dir_q;

    tick_c     = (presc_q == PRE_W'(PRESCALE - 1));
    boundary_c = tick_c && (&pwm_q);
    presc_d    = tick_c ? '0 : presc_q + PRE_W'(1);
    if (tick_c) pwm_d = pwm_q + PW'(1);
    blink_d    = blink_q + BW'(1);
    strobe_d   = boundary_c;

    if (boundary_c && pending_q) begin
      act_mode_d = pend_mode_q;
      act_duty_d = pend_duty_q;
      pending_d  = 1'b0;
    end
    // A LOAD on the boundary cycle lands in pending only, after the old pending moved
    if (bus.LOAD) begin
      pend_mode_d = bus.MODE;
      pend_duty_d = bus.DUTY;
      pending_d   = 1'b1;
    end

    if (boundary_c) begin
      if (div_q == DIV_W'(BREATHE_DIV - 1)) begin
        div_d  = '0;
        step_c = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // Direction turns on arrival at an endpoint so each endpoint lasts one step
    if (step_c) begin
      case (dir_q)
        ST_UP: begin
          level_d = level_q + PW'(1);
          if (level_q == LVL_TOP - PW'(1)) dir_d = ST_DOWN;
        end
        default: begin
          level_d = level_q - PW'(1);
          if (level_q == PW'(1)) dir_d = ST_UP;
        end
      endcase
    end
  end

  // Per-channel compare and pin polarity
  always_comb begin
    led_d   = {CHANNELS{ACTIVE_LOW}};
    ch_mode = MODE_OFF;
    ch_duty = '0;
    ch_eff  = '0;
    ch_sel  = '0;
    ch_cmp  = '0;
    ch_lit  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      ch_mode = act_mode_q[2*k +: 2];
      ch_duty = act_duty_q[PW*k +: PW];
      ch_eff  = PW'(((2*PW)'(ch_duty) * (2*PW)'(level_q)) >> PW);
      ch_sel  = (ch_mode == 2'b11) ? ch_eff : ch_duty;
`ifdef LED_PWM_GAMMA_EN
      ch_cmp  = PW'(((2*PW)'(ch_sel) * (2*PW)'(ch_sel)) >> PW);
`else
      ch_cmp  = ch_sel;
`endif
      case (ch_mode)
        MODE_OFF:    ch_lit = 1'b0;
        MODE_STEADY: ch_lit = (pwm_q < ch_cmp);
        MODE_BLINK:  ch_lit = blink_q[BW-1] && (pwm_q < ch_cmp);
        default:     ch_lit = (pwm_q < ch_cmp);
      endcase
      led_d[k] = ch_lit ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge CLK_48 or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      pwm_q       <= '0;
      blink_q     <= '0;
      strobe_q    <= 1'b0;
      pend_mode_q <= '0;
      pend_duty_q <= '0;
      pending_q   <= 1'b0;
      act_mode_q  <= '0;
      act_duty_q  <= '0;
      div_q       <= '0;
      level_q     <= '0;
      dir_q       <= ST_UP;
      led_q       <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      presc_q     <= presc_d;
      pwm_q       <= pwm_d;
      blink_q     <= blink_d;
      strobe_q    <= strobe_d;
      pend_mode_q <= pend_mode_d;
      pend_duty_q <= pend_duty_d;
      pending_q   <= pending_d;
      act_mode_q  <= act_mode_d;
      act_duty_q  <= act_duty_d;
      div_q       <= div_d;
      level_q     <= level_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
    end
  end

  assign bus.PENDING       = pending_q;
  assign bus.PERIOD_STROBE = strobe_q;
  assign bus.LED           = led_q;

endmodule

// File: tb/tb_led_pwm_pattern.sv
// Bench for led_pwm_pattern with a small timebase (32-clock PWM period).
// Per-cycle reference model plus table-driven and hand-written corner sequences.
module tb_led_pwm_pattern;

  localparam int unsigned CH = 3;
  localparam int unsigned PB = 4;
  localparam int unsigned PS = 2;
  localparam int unsigned BB = 6;
  localparam int unsigned BD = 1;
  localparam bit          AL = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pwm_pattern_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

  led_pwm_pattern #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS),
    .BLINK_BIT(BB), .BREATHE_DIV(BD), .ACTIVE_LOW(AL)
  ) dut (
    .CLK_48(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (time since reset drives everything) ----
  int       m_k;
  bit       m_pend;
  int       pend_mode [CH];
  int       pend_duty [CH];
  int       act_mode [CH];
  int       act_duty [CH];
  logic [2:0] exp_led;
  bit       exp_strobe;

  function automatic int level_at(input int k);
    int s;
    s = (k / 32) % 30;
    return (s <= 15) ? s : 30 - s;
  endfunction

  function automatic int cmp_val(input int mode, input int duty, input int lvl);
    int v;
    v = (mode == 3) ? (duty * lvl) / 16 : duty;
`ifdef LED_PWM_GAMMA_EN
    v = (v * v) / 16;
`endif
    return v;
  endfunction

  function automatic bit lit_at(input int k, input int mode, input int duty);
    int pwm;
    bit bph;
    int v;
    pwm = (k / 2) % 16;
    bph = (k % 128) >= 64;
    v   = cmp_val(mode, duty, level_at(k));
    case (mode)
      0:       return 1'b0;
      1:       return pwm < v;
      2:       return bph && (pwm < v);
      default: return pwm < v;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0;
      m_pend = 1'b0;
      for (int c = 0; c < CH; c++) begin
        pend_mode[c] = 0; pend_duty[c] = 0; act_mode[c] = 0; act_duty[c] = 0;
      end
      exp_led = 3'b111;
      exp_strobe = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) exp_led[c] = lit_at(m_k, act_mode[c], act_duty[c]) ^ AL;
      exp_strobe = (m_k % 32) == 31;
      if (exp_strobe && m_pend) begin
        for (int c = 0; c < CH; c++) begin
          act_mode[c] = pend_mode[c]; act_duty[c] = pend_duty[c];
        end
        m_pend = 1'b0;
      end
      if (bus.LOAD) begin
        for (int c = 0; c < CH; c++) begin
          pend_mode[c] = int'(bus.MODE[2*c +: 2]);
          pend_duty[c] = int'(bus.DUTY[4*c +: 4]);
        end
        m_pend = 1'b1;
      end
      m_k++;
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en)
      check("cycle", 32'({bus.LED, bus.PENDING, bus.PERIOD_STROBE}),
            32'({exp_led, m_pend, exp_strobe}));
  end

  // ---------------- helpers --------------------------------------------------
  task automatic load_vec(input logic [5:0] mode, input logic [11:0] duty);
    bus.MODE = mode;
    bus.DUTY = duty;
    bus.LOAD = 1'b1;
    @(negedge clk);
    bus.LOAD = 1'b0;
  endtask

  task automatic load_one(input int ch, input int mode, input int duty);
    logic [5:0]  mv;
    logic [11:0] dv;
    mv = '0;
    dv = '0;
    mv[2*ch +: 2] = 2'(mode);
    dv[4*ch +: 4] = 4'(duty);
    load_vec(mv, dv);
  endtask

  task automatic wait_strobe();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.PERIOD_STROBE === 1'b1) ok = 1'b1;
    end
    check("strobe_seen", 32'(ok), 32'd1);
  endtask

  task automatic count_lows(input int n, output int l0, output int l1, output int l2);
    l0 = 0; l1 = 0; l2 = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.LED[0] === 1'b0) l0++;
      if (bus.LED[1] === 1'b0) l1++;
      if (bus.LED[2] === 1'b0) l2++;
    end
  endtask

  typedef struct {
    int ch;
    int mode;
    int duty;
    int exp_lows;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   l0, l1, l2, n, lv, v;
    bit   seen;

    tbl[0] = '{0, 1, 4, 8};
    tbl[1] = '{0, 1, 0, 0};
    tbl[2] = '{0, 1, 15, 30};
    tbl[3] = '{1, 1, 9, 18};
    tbl[4] = '{2, 1, 1, 2};
    tbl[5] = '{0, 0, 12, 0};
    tbl[6] = '{2, 1, 15, 30};

    // reset applies with no clock edge, arbitrary inputs present
    bus.MODE = 6'b111001;
    bus.DUTY = 12'($urandom);
    bus.LOAD = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_led", 32'(bus.LED), 32'd7);
    check("rst_pending", 32'(bus.PENDING), 32'd0);
    check("rst_strobe", 32'(bus.PERIOD_STROBE), 32'd0);
    bus.LOAD = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.PERIOD_STROBE === 1'b1) seen = 1'b1;
    end
    check("first_strobe_delay", 32'(n), 32'd32);

    // table: one channel at a time, low-clock count over one full period
    foreach (tbl[i]) begin
      load_one(tbl[i].ch, tbl[i].mode, tbl[i].duty);
      check("pend_set", 32'(bus.PENDING), 32'd1);
      wait_strobe();
      check("pend_clear", 32'(bus.PENDING), 32'd0);
      count_lows(32, l0, l1, l2);
      case (tbl[i].ch)
        0: begin check($sformatf("vec%0d_lows", i), 32'(l0), 32'(tbl[i].exp_lows));
                 check($sformatf("vec%0d_others", i), 32'(l1 + l2), 32'd0); end
        1: begin check($sformatf("vec%0d_lows", i), 32'(l1), 32'(tbl[i].exp_lows));
                 check($sformatf("vec%0d_others", i), 32'(l0 + l2), 32'd0); end
        default: begin check($sformatf("vec%0d_lows", i), 32'(l2), 32'(tbl[i].exp_lows));
                 check($sformatf("vec%0d_others", i), 32'(l0 + l1), 32'd0); end
      endcase
    end

    // blink: dark half of the 128-clock blink period, then two full bursts
    load_one(1, 2, 15);
    wait_strobe();
    for (int i = 0; i < 200 && (m_k % 128) != 0; i++) @(negedge clk);
    count_lows(64, l0, l1, l2);
    check("blink_dark", 32'(l1), 32'd0);
    count_lows(64, l0, l1, l2);
    check("blink_lit", 32'(l1), 32'd60);

    // breathe: one full 30-period envelope on ch2
    load_one(2, 3, 15);
    wait_strobe();
    for (int p = 0; p < 30; p++) begin
      lv = level_at(m_k);
      v  = cmp_val(3, 15, lv);
      count_lows(32, l0, l1, l2);
      check($sformatf("breathe_p%0d_lvl%0d", p, lv), 32'(l2), 32'(2 * v));
    end

    // LOAD on the boundary cycle takes one extra period
    load_one(0, 1, 2);
    wait_strobe();
    for (int i = 0; i < 40 && (m_k % 32) != 31; i++) @(negedge clk);
    load_one(0, 1, 6);
    check("bnd_load_strobe", 32'(bus.PERIOD_STROBE), 32'd1);
    check("bnd_load_pend", 32'(bus.PENDING), 32'd1);
    count_lows(32, l0, l1, l2);
    check("bnd_load_old", 32'(l0), 32'd4);
    check("bnd_load_pend_clr", 32'(bus.PENDING), 32'd0);
    count_lows(32, l0, l1, l2);
    check("bnd_load_new", 32'(l0), 32'd12);

    // two LOADs inside one period: last one wins
    load_one(0, 1, 3);
    repeat (5) @(negedge clk);
    load_one(0, 1, 7);
    wait_strobe();
    count_lows(32, l0, l1, l2);
    check("last_load_wins", 32'(l0), 32'd14);

    // randomized settings and load timing, checked every cycle by the model
    for (int i = 0; i < 40; i++) begin
      load_vec(6'($urandom), 12'($urandom));
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end

    // async reset mid-period clears the active settings
    load_one(0, 1, 15);
    wait_strobe();
    for (int i = 0; i < 40 && (m_k % 32) != 10; i++) @(negedge clk);
    check("pre_rst_lit", 32'(bus.LED[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_led", 32'(bus.LED), 32'd7);
    check("mid_rst_pending", 32'(bus.PENDING), 32'd0);
    check("mid_rst_strobe", 32'(bus.PERIOD_STROBE), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_strobe();
    count_lows(32, l0, l1, l2);
    check("rst_cleared", 32'(l0 + l1 + l2), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
